// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: VGA timing generator with scaled framebuffer scanout and border colour.
// The pixel clock is derived from clk by a divider. H/V counters drive a two-stage pipeline
// so that sync, data-enable and colour leave the block aligned.
// Optional feature macro: VGA_TEST_PATTERN_EN adds a test_mode input that replaces the
// visible colour with eight vertical colour bars and suppresses framebuffer reads.
module vga_fb_scanout #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 11,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 31,
    parameter bit          HS_POL      = 1'b0,
    parameter bit          VS_POL      = 1'b0,
    parameter int unsigned COLOR_BITS  = 2,
    parameter int unsigned IMG_W       = 128,
    parameter int unsigned IMG_H       = 128,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned ADDR_W      = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3*COLOR_BITS-1:0]   border_color,
    output logic [ADDR_W-1:0]         fb_addr,
    output logic                      fb_rd_en,
    input  logic [3*COLOR_BITS-1:0]   fb_data,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      de,
    output logic [COLOR_BITS-1:0]     r,
    output logic [COLOR_BITS-1:0]     g,
    output logic [COLOR_BITS-1:0]     b,
    output logic                      frame_start
`ifdef VGA_TEST_PATTERN_EN
    ,
    input  logic                      test_mode
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned X_W     = $clog2(H_TOTAL);
    localparam int unsigned Y_W     = $clog2(V_TOTAL);
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PIX_W   = 3 * COLOR_BITS;
    localparam int unsigned HS_LO   = H_ACTIVE + H_FP;
    localparam int unsigned HS_HI   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_LO   = V_ACTIVE + V_FP;
    localparam int unsigned VS_HI   = V_ACTIVE + V_FP + V_SYNC;
    // Image extent on screen, clipped to the visible area (no border on a clipped axis).
    localparam int unsigned IMG_XS  = IMG_W << SCALE_SHIFT;
    localparam int unsigned IMG_YS  = IMG_H << SCALE_SHIFT;
    localparam int unsigned IMG_XE  = (IMG_XS < H_ACTIVE) ? IMG_XS : H_ACTIVE;
    localparam int unsigned IMG_YE  = (IMG_YS < V_ACTIVE) ? IMG_YS : V_ACTIVE;

    // Timing state
    logic [DIV_W-1:0]  r_div;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [ADDR_W-1:0] r_row_base;
    logic              r_frame_start;

    // Stage 1: attributes of the pixel whose counter position was just left
    logic              r_s1_hs;
    logic              r_s1_vs;
    logic              r_s1_de;
    logic              r_s1_img;
    logic [PIX_W-1:0]  r_s1_border;

    // Stage 2: pin registers
    logic              r_hs;
    logic              r_vs;
    logic              r_de;
    logic [PIX_W-1:0]  r_rgb;

    // Decoded counter state
    logic              w_pix_tick;
    logic              w_x_last;
    logic              w_y_last;
    logic [Y_W-1:0]    w_y_inc;
    logic              w_sy_step;
    logic              w_h_vis;
    logic              w_v_vis;
    logic              w_in_img;
    logic              w_hs_act;
    logic              w_vs_act;
    logic              w_tm;
    logic [PIX_W-1:0]  w_colour;

    assign w_pix_tick = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_x_last   = (r_x == X_W'(H_TOTAL - 1));
    assign w_y_last   = (r_y == Y_W'(V_TOTAL - 1));
    assign w_y_inc    = r_y + Y_W'(1);
    // Source row changes when the next line maps to a different source row.
    assign w_sy_step  = ((w_y_inc >> SCALE_SHIFT) != (r_y >> SCALE_SHIFT));
    assign w_h_vis    = (r_x < X_W'(H_ACTIVE));
    assign w_v_vis    = (r_y < Y_W'(V_ACTIVE));
    assign w_in_img   = (r_x < X_W'(IMG_XE)) && (r_y < Y_W'(IMG_YE));
    assign w_hs_act   = (r_x >= X_W'(HS_LO)) && (r_x < X_W'(HS_HI));
    assign w_vs_act   = (r_y >= Y_W'(VS_LO)) && (r_y < Y_W'(VS_HI));

`ifdef VGA_TEST_PATTERN_EN
    logic              r_s1_tm;
    logic [2:0]        r_s1_bar;
    logic [2:0]        w_bar;

    assign w_tm = test_mode;

    // Bar index (x*8)/H_ACTIVE as a chain of constant threshold compares
    always_comb begin
        w_bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (r_x >= X_W'((k * H_ACTIVE + 7) / 8)) begin
                w_bar = 3'(k);
            end
        end
    end

    // Test-mode controls sampled alongside the rest of stage 1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_tm  <= 1'b0;
            r_s1_bar <= 3'd0;
        end else if (w_pix_tick) begin
            r_s1_tm  <= w_tm;
            r_s1_bar <= w_bar;
        end
    end
`else
    assign w_tm = 1'b0;
`endif

    // Framebuffer request: address held for the whole pixel period, strobe on its last clk
    assign fb_addr  = r_row_base + ADDR_W'(r_x >> SCALE_SHIFT);
    assign fb_rd_en = w_pix_tick & w_in_img & ~w_tm;

    // Pixel-rate divider
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_pix_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // H/V counters, incremental framebuffer row base and frame-start pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x           <= '0;
            r_y           <= '0;
            r_row_base    <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_pix_tick && w_x_last && w_y_last;
            if (w_pix_tick) begin
                if (w_x_last) begin
                    r_x <= '0;
                    if (w_y_last) begin
                        r_y        <= '0;
                        r_row_base <= '0;
                    end else begin
                        r_y <= w_y_inc;
                        if (w_sy_step) begin
                            r_row_base <= r_row_base + ADDR_W'(IMG_W);
                        end
                    end
                end else begin
                    r_x <= r_x + X_W'(1);
                end
            end
        end
    end

    // Stage 1: capture sync/enable/region/border for the current position
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_hs     <= !HS_POL;
            r_s1_vs     <= !VS_POL;
            r_s1_de     <= 1'b0;
            r_s1_img    <= 1'b0;
            r_s1_border <= '0;
        end else if (w_pix_tick) begin
            r_s1_hs     <= w_hs_act ? HS_POL : !HS_POL;
            r_s1_vs     <= w_vs_act ? VS_POL : !VS_POL;
            r_s1_de     <= w_h_vis && w_v_vis;
            r_s1_img    <= w_in_img;
            r_s1_border <= border_color;
        end
    end

    // Colour select for the stage-1 pixel; fb_data holds its word by now
    always_comb begin
        w_colour = '0;
        if (r_s1_de) begin
            if (r_s1_img) begin
                w_colour = fb_data;
            end else begin
                w_colour = r_s1_border;
            end
`ifdef VGA_TEST_PATTERN_EN
            if (r_s1_tm) begin
                w_colour = {{COLOR_BITS{r_s1_bar[2]}},
                            {COLOR_BITS{r_s1_bar[1]}},
                            {COLOR_BITS{r_s1_bar[0]}}};
            end
`endif
        end
    end

    // Stage 2: pin registers, all updated on the same pixel boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs  <= !HS_POL;
            r_vs  <= !VS_POL;
            r_de  <= 1'b0;
            r_rgb <= '0;
        end else if (w_pix_tick) begin
            r_hs  <= r_s1_hs;
            r_vs  <= r_s1_vs;
            r_de  <= r_s1_de;
            r_rgb <= w_colour;
        end
    end

    assign hsync       = r_hs;
    assign vsync       = r_vs;
    assign de          = r_de;
    assign r           = r_rgb[3*COLOR_BITS-1:2*COLOR_BITS];
    assign g           = r_rgb[2*COLOR_BITS-1:COLOR_BITS];
    assign b           = r_rgb[COLOR_BITS-1:0];
    assign frame_start = r_frame_start;

endmodule
